// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from the TX FIFO and serialises them as
// start, DBIT data bits LSB-first, optional parity, and stop period, paced by a 16x baud tick.
module uart_tx_fifo_drain #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    state_t          state, state_n;
    logic [4:0]      s_cnt, s_cnt_n;
    logic [2:0]      n_cnt, n_cnt_n;
    logic [DBIT-1:0] b_reg, b_n;
    logic            par_reg, par_n;
    logic            tx_reg, tx_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            s_cnt   <= '0;
            n_cnt   <= '0;
            b_reg   <= '0;
            par_reg <= 1'b0;
            tx_reg  <= 1'b1;
        end else begin
            state   <= state_n;
            s_cnt   <= s_cnt_n;
            n_cnt   <= n_cnt_n;
            b_reg   <= b_n;
            par_reg <= par_n;
            tx_reg  <= tx_n;
        end
    end

    always_comb begin
        state_n      = state;
        s_cnt_n      = s_cnt;
        n_cnt_n      = n_cnt;
        b_n          = b_reg;
        par_n        = par_reg;
        tx_n         = 1'b1;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        case (state)
            IDLE: begin
                // Pop and latch in one cycle; any tick seen here is deliberately ignored.
                if (!fifo_empty && reset_n) begin
                    fifo_rd = 1'b1;
                    b_n     = fifo_r_data;
                    par_n   = (^fifo_r_data) ^ ODD;
                    s_cnt_n = '0;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (s_tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_cnt_n = '0;
                        n_cnt_n = '0;
                        state_n = DATA;
                    end else begin
                        s_cnt_n = s_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                tx_n = b_reg[0];
                if (s_tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_cnt_n = '0;
                        b_n     = b_reg >> 1;
                        if (n_cnt == N_LAST)
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            n_cnt_n = n_cnt + 3'd1;
                    end else begin
                        s_cnt_n = s_cnt + 5'd1;
                    end
                end
            end
            PARITY: begin
                tx_n = par_reg;
                if (s_tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_cnt_n = '0;
                        state_n = STOP;
                    end else begin
                        s_cnt_n = s_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == STOP_LAST) begin
                        s_cnt_n      = '0;
                        tx_done_tick = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        s_cnt_n = s_cnt + 5'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Drives four transmitter variants (plain, even parity, odd parity + 2 stop, 2 stop) from
// queue-based FIFO models; monitors decode each frame by tick count and compare to a scoreboard.
module tb_uart_tx_fifo_drain;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic s_tick = 1'b0;
    int   ph = 0;

    logic [NI-1:0] tx, tx_busy, fifo_rd, tx_done_tick;
    logic          fifo_empty [NI];
    logic [7:0]    r_data [NI];

    logic [7:0] fifo_q [NI][$];
    logic [7:0] exp_q  [NI][$];
    int pushes [NI];
    int pops [NI];
    int frames [NI];
    int aborted [NI];
    bit frame_on [NI];
    int ticks [NI];
    int rd_bad = 0;
    int idle_bad = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ph = (ph == 3) ? 0 : ph + 1;
        s_tick = (ph == 0);
    end

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int PE = (g == 1 || g == 2) ? 1 : 0;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g >= 2) ? 32 : 16;
        localparam int NB = 10 + PE;
        localparam int NT = (9 + PE) * 16 + SB;

        uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(SB), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
            .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
            .fifo_empty(fifo_empty[g]), .fifo_r_data(r_data[g]),
            .fifo_rd(fifo_rd[g]), .tx(tx[g]), .tx_busy(tx_busy[g]), .tx_done_tick(tx_done_tick[g])
        );

        // Expected line levels for one frame, indexed by bit slot: start, data, [parity], stop.
        function automatic logic [11:0] frame_bits(logic [7:0] b);
            logic [11:0] e;
            e = '0;
            for (int j = 0; j < 8; j++) e[1 + j] = b[j];
            if (PE != 0) e[9] = (($countones(b) % 2) == 1) ^ (PO != 0);
            e[NB - 1] = 1'b1;
            return e;
        endfunction

        initial begin
            logic rd_pend;
            logic [11:0] rx;
            logic [7:0] b;
            bit on, nxt;
            int tk, bbad;
            fifo_empty[g] = 1'b1;
            r_data[g] = 8'h00;
            on = 0; nxt = 0; tk = 0; bbad = 0; rx = '0;
            forever begin
                @(negedge clk);
                rd_pend = fifo_rd[g];
                if (!reset_n) begin
                    aborted[g] += exp_q[g].size();
                    exp_q[g].delete();
                    on = 0;
                    nxt = 0;
                end else begin
                    if (fifo_rd[g] && fifo_empty[g]) rd_bad++;
                    if (nxt) begin
                        nxt = 0;
                        if (!fifo_empty[g]) chk($sformatf("b2b_pop%0d", g), fifo_rd[g], 1);
                    end
                    if (on) begin
                        if (!tx_busy[g] || fifo_rd[g]) bbad++;
                        if (s_tick) begin
                            tk++;
                            if (tk % 16 == 8 && tk / 16 < NB) rx[tk / 16] = tx[g];
                        end
                        if (tx_done_tick[g]) begin
                            on = 0;
                            nxt = 1;
                            frames[g]++;
                            chk($sformatf("frame_ticks%0d", g), tk, NT);
                            chk($sformatf("busy_frame%0d", g), bbad, 0);
                            chk($sformatf("tx_at_done%0d", g), tx[g], 1);
                            if (exp_q[g].size() == 0) begin
                                chk($sformatf("unexpected_frame%0d", g), 0, 1);
                            end else begin
                                b = exp_q[g].pop_front();
                                chk($sformatf("frame_bits%0d", g), rx, frame_bits(b));
                            end
                        end
                    end else begin
                        if (tx_busy[g] || tx_done_tick[g]) idle_bad++;
                        if (fifo_rd[g]) begin
                            on = 1;
                            tk = 0;
                            bbad = 0;
                            rx = '0;
                        end
                    end
                end
                frame_on[g] = on;
                ticks[g] = tk;
                @(posedge clk);
                #1;
                if (rd_pend && fifo_q[g].size() > 0) begin
                    exp_q[g].push_back(fifo_q[g].pop_front());
                    pops[g]++;
                end
                #2;
                fifo_empty[g] = (fifo_q[g].size() == 0);
                r_data[g] = fifo_empty[g] ? 8'h00 : fifo_q[g][0];
            end
        end
    end

    task automatic push_all(logic [7:0] b);
        for (int i = 0; i < NI; i++) begin
            fifo_q[i].push_back(b);
            pushes[i]++;
        end
    endtask

    function automatic bit all_idle();
        bit r;
        r = 1;
        for (int i = 0; i < NI; i++)
            if (!fifo_empty[i] || frame_on[i] || fifo_q[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!all_idle() && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(n < budget), 1);
    endtask

    initial begin
        int n, total;
        logic [7:0] rb;
        for (int i = 0; i < NI; i++) begin
            pushes[i] = 0; pops[i] = 0; frames[i] = 0; aborted[i] = 0;
            frame_on[i] = 0; ticks[i] = 0;
        end
        repeat (3) @(posedge clk);
        #3;
        chk("reset_tx", tx, 4'hF);
        chk("reset_busy", tx_busy, 0);
        chk("reset_rd", fifo_rd, 0);
        chk("reset_done", tx_done_tick, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        repeat (1000) @(posedge clk);
        #3;
        total = 0;
        for (int i = 0; i < NI; i++) total += pops[i];
        chk("idle_tx", tx, 4'hF);
        chk("idle_pops", total, 0);

        @(posedge clk); #2;
        push_all(8'hA5);
        wait_idle(3000);

        @(posedge clk); #2;
        push_all(8'h00); push_all(8'hFF); push_all(8'h3C);
        wait_idle(8000);

        @(posedge clk); #2;
        push_all(8'h07); push_all(8'h55);
        wait_idle(6000);

        for (int r = 0; r < 24; r++) begin
            @(posedge clk); #2;
            for (int i = 0; i < NI; i++)
                if ($urandom_range(0, 1) == 1) begin
                    fifo_q[i].push_back(8'($urandom));
                    pushes[i]++;
                end
            repeat ($urandom_range(0, 1200)) @(posedge clk);
        end
        wait_idle(25000);

        // Abort a frame while variant 0 is in its fourth data bit.
        @(posedge clk); #2;
        rb = 8'($urandom);
        push_all(rb);
        n = 0;
        @(negedge clk);
        while (!(frame_on[0] && ticks[0] >= 70) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit3", int'(n < 3000), 1);
        chk("busy_mid", tx_busy[0], 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("abort_tx", tx, 4'hF);
        chk("abort_busy", tx_busy, 0);
        chk("abort_rd", fifo_rd, 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #2;
        push_all(~rb);
        wait_idle(4000);

        for (int i = 0; i < NI; i++) begin
            chk($sformatf("frame_count%0d", i), frames[i] + aborted[i], pushes[i]);
            chk($sformatf("pop_count%0d", i), pops[i], pushes[i]);
        end
        chk("rd_while_empty", rd_bad, 0);
        chk("busy_or_done_idle", idle_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
